// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state encoding and constants for fetch_ctrl
package fetch_pkg;

  localparam int          INSTR_W = 32;
  localparam int          CNT_W   = 32;
  localparam logic [31:0] PC_INC  = 32'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    VALID = 2'd2,
    ERR   = 2'd3
  } fetch_state_e;

  // Every pc load is word aligned regardless of the target's low bits.
  function automatic logic [31:0] align_pc(input logic [31:0] target);
    return target & ~32'd3;
  endfunction

endpackage

// File: rtl/fetch_perf_cnt.sv
// rtl/fetch_perf_cnt.sv - wrapping fetch/redirect event counters (FETCH_CTRL_PERF_EN)
module fetch_perf_cnt
  import fetch_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_inc_i,
  input  logic             redirect_inc_i,
  output logic [CNT_W-1:0] fetch_count_o,
  output logic [CNT_W-1:0] redirect_count_o
);

  logic [CNT_W-1:0] fetch_q, fetch_d;
  logic [CNT_W-1:0] redir_q, redir_d;

  always_comb begin
    fetch_d = fetch_q;
    redir_d = redir_q;
    if (fetch_inc_i) begin
      fetch_d = fetch_q + 1'b1;
    end
    if (redirect_inc_i) begin
      redir_d = redir_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_q <= '0;
      redir_q <= '0;
    end else begin
      fetch_q <= fetch_d;
      redir_q <= redir_d;
    end
  end

  assign fetch_count_o    = fetch_q;
  assign redirect_count_o = redir_q;

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch FSM with redirect kill and ack timeout
// Optional perf counters enabled by FETCH_CTRL_PERF_EN.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pcsrc,
  input  logic [31:0]        mux1,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] instruction,
  output logic               instr_valid,
  output logic [31:0]        adderOutput,
  output logic               fetch_err
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0]   fetch_count,
  output logic [CNT_W-1:0]   redirect_count
`endif
);

  localparam int              TO_W     = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(ACK_TIMEOUT);

  fetch_state_e       state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        redir_q, redir_d;
  logic               kill_q, kill_d;
  logic               err_q, err_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    redir_d  = redir_q;
    kill_d   = kill_q;
    err_d    = err_q;
    instr_d  = instr_q;
    to_cnt_d = to_cnt_q;

    case (state_q)
      IDLE: begin
        to_cnt_d = '0;
        state_d  = REQ;
      end

      REQ: begin
        if (imem_ack) begin
          to_cnt_d = '0;
          // A redirect seen during the request kills the returning data.
          if (pcsrc) begin
            pc_d   = align_pc(mux1);
            kill_d = 1'b0;
          end else if (kill_q) begin
            pc_d   = redir_q;
            kill_d = 1'b0;
          end else begin
            instr_d = imem_rdata;
            state_d = VALID;
          end
        end else begin
          if (pcsrc) begin
            redir_d = align_pc(mux1);
            kill_d  = 1'b1;
          end
          to_cnt_d = to_cnt_q + 1'b1;
          if (to_cnt_d == TO_LIMIT) begin
            err_d   = 1'b1;
            state_d = ERR;
          end
        end
      end

      VALID: begin
        if (pcsrc) begin
          pc_d    = align_pc(mux1);
          state_d = REQ;
        end else if (if_ready) begin
          pc_d    = pc_q + PC_INC;
          state_d = REQ;
        end
      end

      ERR: begin
        state_d = ERR;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      redir_q  <= '0;
      kill_q   <= 1'b0;
      err_q    <= 1'b0;
      instr_q  <= '0;
      to_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      redir_q  <= redir_d;
      kill_q   <= kill_d;
      err_q    <= err_d;
      instr_q  <= instr_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  assign imem_req    = (state_q == REQ);
  assign imem_addr   = pc_q;
  assign instruction = instr_q;
  assign instr_valid = (state_q == VALID);
  assign adderOutput = pc_q + PC_INC;
  assign fetch_err   = err_q;

`ifdef FETCH_CTRL_PERF_EN
  logic fetch_inc;
  logic redirect_inc;

  assign fetch_inc    = (state_q == VALID) && !pcsrc && if_ready;
  assign redirect_inc = ((state_q == REQ) && imem_ack && (kill_q || pcsrc)) ||
                        ((state_q == VALID) && pcsrc);

  fetch_perf_cnt u_perf (
    .clk              (clk),
    .rst              (rst),
    .fetch_inc_i      (fetch_inc),
    .redirect_inc_i   (redirect_inc),
    .fetch_count_o    (fetch_count),
    .redirect_count_o (redirect_count)
  );
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - self-checking bench for fetch_ctrl (vectors, corner sequences, random vs model)
module tb_fetch_ctrl;

  localparam int ACK_TO = 16;

  logic        clk;
  logic        rst;
  logic        pcsrc;
  logic [31:0] mux1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_ready;
  logic [31:0] instruction;
  logic        instr_valid;
  logic [31:0] adderOutput;
  logic        fetch_err;
`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] fetch_count;
  logic [31:0] redirect_count;
`endif

  fetch_ctrl #(
    .RESET_PC    (32'h0000_0000),
    .ACK_TIMEOUT (ACK_TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pcsrc       (pcsrc),
    .mux1        (mux1),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .if_ready    (if_ready),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .adderOutput (adderOutput),
    .fetch_err   (fetch_err)
`ifdef FETCH_CTRL_PERF_EN
    ,
    .fetch_count    (fetch_count),
    .redirect_count (redirect_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // ctl = {rst, pcsrc, ack, ready}; flg = {imem_req, instr_valid, fetch_err}
  typedef struct packed {
    logic [3:0]  ctl;
    logic [31:0] mux1;
    logic [31:0] rdata;
    logic [2:0]  flg;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] adder;
  } vec_t;

  vec_t vt[20];

  function automatic vec_t mk(input logic [3:0] c, input logic [31:0] m, input logic [31:0] d,
                              input logic [2:0] f, input logic [31:0] a, input logic [31:0] i,
                              input logic [31:0] s);
    vec_t v;
    v.ctl = c; v.mux1 = m; v.rdata = d; v.flg = f; v.addr = a; v.instr = i; v.adder = s;
    return v;
  endfunction

  task automatic chk1(input string nm, input logic got, input logic exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", nm, got, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic expect_outs(input string tag, input logic e_req, input logic [31:0] e_addr,
                             input logic e_valid, input logic [31:0] e_instr,
                             input logic [31:0] e_adder, input logic e_err);
    chk1 ({tag, " imem_req"},    imem_req,    e_req);
    chk32({tag, " imem_addr"},   imem_addr,   e_addr);
    chk1 ({tag, " instr_valid"}, instr_valid, e_valid);
    chk32({tag, " instruction"}, instruction, e_instr);
    chk32({tag, " adderOutput"}, adderOutput, e_adder);
    chk1 ({tag, " fetch_err"},   fetch_err,   e_err);
  endtask

  task automatic cyc(input logic r, input logic p, input logic [31:0] m,
                     input logic a, input logic [31:0] d, input logic y);
    rst = r; pcsrc = p; mux1 = m; imem_ack = a; imem_rdata = d; if_ready = y;
    @(posedge clk);
    #1;
  endtask

  // Reference model: fetch/hold/error phases, a pending-redirect queue (last wins),
  // and a count of unanswered request cycles.
  bit          m_fetch, m_hold, m_err;
  logic [31:0] m_pc, m_instr;
  logic [31:0] m_redir[$];
  int          m_wait;
  logic [31:0] m_fc, m_rc;

  task automatic model_reset();
    m_fetch = 0; m_hold = 0; m_err = 0;
    m_pc = 32'h0; m_instr = 32'h0;
    m_redir.delete();
    m_wait = 0; m_fc = 32'h0; m_rc = 32'h0;
  endtask

  task automatic model_step(input logic r, input logic p, input logic [31:0] m,
                            input logic a, input logic [31:0] d, input logic y);
    if (r) begin
      model_reset();
    end else if (m_err) begin
      m_err = 1;
    end else if (m_hold) begin
      if (p) begin
        m_pc = m & 32'hFFFF_FFFC; m_hold = 0; m_fetch = 1; m_rc = m_rc + 1;
      end else if (y) begin
        m_pc = m_pc + 32'd4; m_hold = 0; m_fetch = 1; m_fc = m_fc + 1;
      end
    end else if (m_fetch) begin
      if (a) begin
        m_wait = 0;
        if (p) begin
          m_pc = m & 32'hFFFF_FFFC; m_redir.delete(); m_rc = m_rc + 1;
        end else if (m_redir.size() != 0) begin
          m_pc = m_redir.pop_front(); m_rc = m_rc + 1;
        end else begin
          m_instr = d; m_fetch = 0; m_hold = 1;
        end
      end else begin
        if (p) begin
          m_redir.delete();
          m_redir.push_back(m & 32'hFFFF_FFFC);
        end
        m_wait++;
        if (m_wait == ACK_TO) begin
          m_err = 1; m_fetch = 0;
        end
      end
    end else begin
      m_fetch = 1;
    end
  endtask

  logic        rr, rp, ra, ry;
  logic [31:0] rm, rd;
  int          ack_pct;

  initial begin
    rst = 1'b1; pcsrc = 1'b0; mux1 = 32'h0; imem_ack = 1'b0; imem_rdata = 32'h0; if_ready = 1'b0;

    // Sequential fetch, 5-cycle stall at pc=8, then redirect beating accept.
    vt[0]  = mk(4'b1000, 32'h0,   32'h0,  3'b000, 32'h0,   32'h0,  32'h4);
    vt[1]  = mk(4'b0000, 32'h0,   32'h0,  3'b100, 32'h0,   32'h0,  32'h4);
    vt[2]  = mk(4'b0000, 32'h0,   32'h0,  3'b100, 32'h0,   32'h0,  32'h4);
    vt[3]  = mk(4'b0010, 32'h0,   32'h11, 3'b010, 32'h0,   32'h11, 32'h4);
    vt[4]  = mk(4'b0001, 32'h0,   32'h0,  3'b100, 32'h4,   32'h11, 32'h8);
    vt[5]  = mk(4'b0000, 32'h0,   32'h0,  3'b100, 32'h4,   32'h11, 32'h8);
    vt[6]  = mk(4'b0010, 32'h0,   32'h22, 3'b010, 32'h4,   32'h22, 32'h8);
    vt[7]  = mk(4'b0001, 32'h0,   32'h0,  3'b100, 32'h8,   32'h22, 32'hC);
    vt[8]  = mk(4'b0000, 32'h0,   32'h0,  3'b100, 32'h8,   32'h22, 32'hC);
    vt[9]  = mk(4'b0010, 32'h0,   32'h33, 3'b010, 32'h8,   32'h33, 32'hC);
    for (int i = 10; i < 15; i++) begin
      vt[i] = mk(4'b0010, 32'h0,  32'hEE, 3'b010, 32'h8,   32'h33, 32'hC);
    end
    vt[15] = mk(4'b0001, 32'h0,   32'h0,  3'b100, 32'hC,   32'h33, 32'h10);
    vt[16] = mk(4'b0010, 32'h0,   32'h44, 3'b010, 32'hC,   32'h44, 32'h10);
    vt[17] = mk(4'b0001, 32'h0,   32'h0,  3'b100, 32'h10,  32'h44, 32'h14);
    vt[18] = mk(4'b0010, 32'h0,   32'h55, 3'b010, 32'h10,  32'h55, 32'h14);
    vt[19] = mk(4'b0101, 32'h103, 32'h0,  3'b100, 32'h100, 32'h55, 32'h104);

    for (int i = 0; i < 20; i++) begin
      cyc(vt[i].ctl[3], vt[i].ctl[2], vt[i].mux1, vt[i].ctl[1], vt[i].rdata, vt[i].ctl[0]);
      expect_outs($sformatf("vec%0d", i), vt[i].flg[2], vt[i].addr, vt[i].flg[1],
                  vt[i].instr, vt[i].adder, vt[i].flg[0]);
    end

    // Ack during and right after reset is ignored; redirect while request in flight.
    cyc(1'b1, 1'b0, 32'h0,  1'b1, 32'h99,   1'b0); expect_outs("rstack0", 1'b0, 32'h0,  1'b0, 32'h0,  32'h4,  1'b0);
    cyc(1'b0, 1'b0, 32'h0,  1'b1, 32'h98,   1'b0); expect_outs("rstack1", 1'b1, 32'h0,  1'b0, 32'h0,  32'h4,  1'b0);
    cyc(1'b0, 1'b0, 32'h0,  1'b1, 32'hA0,   1'b0); expect_outs("kill_a",  1'b0, 32'h0,  1'b1, 32'hA0, 32'h4,  1'b0);
    cyc(1'b0, 1'b0, 32'h0,  1'b0, 32'h0,    1'b1); expect_outs("kill_b",  1'b1, 32'h4,  1'b0, 32'hA0, 32'h8,  1'b0);
    cyc(1'b0, 1'b0, 32'h0,  1'b1, 32'hA4,   1'b0); expect_outs("kill_c",  1'b0, 32'h4,  1'b1, 32'hA4, 32'h8,  1'b0);
    cyc(1'b0, 1'b0, 32'h0,  1'b0, 32'h0,    1'b1); expect_outs("kill_d",  1'b1, 32'h8,  1'b0, 32'hA4, 32'hC,  1'b0);
    cyc(1'b0, 1'b1, 32'h40, 1'b0, 32'h0,    1'b1); expect_outs("kill_e",  1'b1, 32'h8,  1'b0, 32'hA4, 32'hC,  1'b0);
    cyc(1'b0, 1'b0, 32'h0,  1'b0, 32'h0,    1'b1); expect_outs("kill_f",  1'b1, 32'h8,  1'b0, 32'hA4, 32'hC,  1'b0);
    cyc(1'b0, 1'b0, 32'h0,  1'b0, 32'h0,    1'b1); expect_outs("kill_g",  1'b1, 32'h8,  1'b0, 32'hA4, 32'hC,  1'b0);
    cyc(1'b0, 1'b0, 32'h0,  1'b1, 32'hDEAD, 1'b1); expect_outs("kill_h",  1'b1, 32'h40, 1'b0, 32'hA4, 32'h44, 1'b0);
    cyc(1'b0, 1'b0, 32'h0,  1'b1, 32'hB0,   1'b0); expect_outs("kill_i",  1'b0, 32'h40, 1'b1, 32'hB0, 32'h44, 1'b0);

    // pc wrap at the top of the address space.
    cyc(1'b1, 1'b0, 32'h0,          1'b0, 32'h0,   1'b0); expect_outs("wrap_a", 1'b0, 32'h0,          1'b0, 32'h0,  32'h4, 1'b0);
    cyc(1'b0, 1'b0, 32'h0,          1'b0, 32'h0,   1'b0); expect_outs("wrap_b", 1'b1, 32'h0,          1'b0, 32'h0,  32'h4, 1'b0);
    cyc(1'b0, 1'b1, 32'hFFFF_FFFF,  1'b1, 32'hBAD, 1'b0); expect_outs("wrap_c", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0,  32'h0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0,          1'b1, 32'hC0,  1'b0); expect_outs("wrap_d", 1'b0, 32'hFFFF_FFFC, 1'b1, 32'hC0, 32'h0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0,          1'b0, 32'h0,   1'b1); expect_outs("wrap_e", 1'b1, 32'h0,          1'b0, 32'hC0, 32'h4, 1'b0);

    // Ack timeout, sticky error, recovery only through reset.
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0); expect_outs("to_a", 1'b0, 32'h0, 1'b0, 32'h0, 32'h4, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0); expect_outs("to_b", 1'b1, 32'h0, 1'b0, 32'h0, 32'h4, 1'b0);
    for (int i = 0; i < ACK_TO - 1; i++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    end
    expect_outs("to_15", 1'b1, 32'h0, 1'b0, 32'h0, 32'h4, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    expect_outs("to_16", 1'b0, 32'h0, 1'b0, 32'h0, 32'h4, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 32'h40, 1'b1, 32'h11, 1'b1);
      expect_outs($sformatf("to_err%0d", i), 1'b0, 32'h0, 1'b0, 32'h0, 32'h4, 1'b1);
    end
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    expect_outs("to_rst", 1'b0, 32'h0, 1'b0, 32'h0, 32'h4, 1'b0);

    // Random traffic against the reference model.
    model_reset();
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      ack_pct = ((i / 250) % 2 == 0) ? 50 : 4;
      rr = ($urandom_range(0, 199) == 0);
      rp = ($urandom_range(0, 99) < 12);
      rm = $urandom();
      if ($urandom_range(0, 9) == 0) rm = 32'hFFFF_FFFC | (rm & 32'h3);
      ra = ($urandom_range(0, 99) < ack_pct);
      rd = $urandom();
      ry = ($urandom_range(0, 99) < 60);
      cyc(rr, rp, rm, ra, rd, ry);
      model_step(rr, rp, rm, ra, rd, ry);
      expect_outs($sformatf("rand%0d", i), m_fetch, m_pc, m_hold, m_instr, m_pc + 32'd4, m_err);
`ifdef FETCH_CTRL_PERF_EN
      chk32($sformatf("rand%0d fetch_count", i), fetch_count, m_fc);
      chk32($sformatf("rand%0d redirect_count", i), redirect_count, m_rc);
`endif
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
